// File: rtl/control_pkg.sv
// control_pkg: opcodes, control codes, FSM states and the raw control bundle for the 16-bit CPU decoder
// Optional feature macro: CTRL_ILLEGAL_OP_EN adds an illegalOp flag to the control bundle.
package control_pkg;

    localparam logic [3:0] OP_TYPEA = 4'b1111;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b0000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_RD    = 2'b01;
    localparam logic [1:0] RW_RD_R0 = 2'b10;

    localparam logic [1:0] JB_SEQ  = 2'b00;
    localparam logic [1:0] JB_BR   = 2'b01;
    localparam logic [1:0] JB_JMP  = 2'b10;
    localparam logic [1:0] JB_HALT = 2'b11;

    typedef enum logic {ST_RUN, ST_HALTED} stateT;

    typedef struct packed {
        logic       aluBType;
        logic       aluSrc;
        logic       signExtendFlag;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic [1:0] aluControl;
        logic [1:0] regWrite;
        logic [1:0] jumpBranch;
`ifdef CTRL_ILLEGAL_OP_EN
        logic       illegalOp;
`endif
    } ctrlT;

    // Bundle held while halted: everything quiet except the halt indication.
    function automatic ctrlT haltCtrl();
        ctrlT c;
        c = '0;
        c.jumpBranch = JB_HALT;
        return c;
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode/multiDiv to raw control bundle decode
// Optional feature macro: CTRL_ILLEGAL_OP_EN flags undefined opcodes.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       multiDiv,
    output ctrlT       ctrl
);

    // Every field defaults to 0 so undefined opcodes fall through as NOPs.
    always_comb begin
        ctrl = '0;
        ctrl.aluControl = ALU_ADD;
        ctrl.regWrite = RW_NONE;
        ctrl.jumpBranch = JB_SEQ;
        case (opcode)
            OP_TYPEA: begin
                ctrl.aluBType = 1'b1;
                ctrl.regWrite = multiDiv ? RW_RD_R0 : RW_RD;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.aluSrc = 1'b1;
                ctrl.aluControl = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                ctrl.regWrite = RW_RD;
            end
            OP_LBU, OP_LW: begin
                ctrl.aluSrc = 1'b1;
                ctrl.signExtendFlag = 1'b1;
                ctrl.memRead = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.regWrite = RW_RD;
            end
            OP_SB, OP_SW: begin
                ctrl.aluSrc = 1'b1;
                ctrl.signExtendFlag = 1'b1;
                ctrl.memWrite = 1'b1;
            end
            OP_BLT, OP_BGT, OP_BEQ: begin
                ctrl.signExtendFlag = 1'b1;
                ctrl.aluControl = ALU_SUB;
                ctrl.jumpBranch = JB_BR;
            end
            OP_JMP:  ctrl.jumpBranch = JB_JMP;
            OP_HALT: ctrl.jumpBranch = JB_HALT;
            default: begin
`ifdef CTRL_ILLEGAL_OP_EN
                ctrl.illegalOp = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: registered main decoder with stall hold and sticky HALT state
// Optional feature macro: CTRL_ILLEGAL_OP_EN adds the registered illegalOp output.
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [3:0] opcode,
    input  logic       multiDiv,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       signExtendFlag,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic [1:0] aluControl,
    output logic [1:0] regWrite,
    output logic [1:0] jumpBranch
`ifdef CTRL_ILLEGAL_OP_EN
    ,
    output logic       illegalOp
`endif
);

    stateT state, nextState;
    ctrlT  ctrlQ, ctrlD, decoded;

    control_decode uDecode (
        .opcode   (opcode),
        .multiDiv (multiDiv),
        .ctrl     (decoded)
    );

    // Next bundle/state: hold on stall, freeze at halt decode once halted.
    always_comb begin
        ctrlD = ctrlQ;
        nextState = state;
        if (!stall) begin
            ctrlD = (state == ST_HALTED) ? haltCtrl() : decoded;
            nextState = (state == ST_HALTED || opcode == OP_HALT) ? ST_HALTED : ST_RUN;
        end
    end

    // Output flops and FSM state; reset clears both without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            ctrlQ <= '0;
        end else begin
            state <= nextState;
            ctrlQ <= ctrlD;
        end
    end

    assign aluBType       = ctrlQ.aluBType;
    assign aluSrc         = ctrlQ.aluSrc;
    assign signExtendFlag = ctrlQ.signExtendFlag;
    assign memRead        = ctrlQ.memRead;
    assign memToReg       = ctrlQ.memToReg;
    assign memWrite       = ctrlQ.memWrite;
    assign aluControl     = ctrlQ.aluControl;
    assign regWrite       = ctrlQ.regWrite;
    assign jumpBranch     = ctrlQ.jumpBranch;
`ifdef CTRL_ILLEGAL_OP_EN
    assign illegalOp      = ctrlQ.illegalOp;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized check of control_unit against a rule-level reference model
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] opcode = 4'hF;
    logic       multiDiv = 1'b1;
    logic       aluBType, aluSrc, signExtendFlag, memRead, memToReg, memWrite;
    logic [1:0] aluControl, regWrite, jumpBranch;
    logic       illegalBit;

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] expVec = '0;
    logic        halted = 1'b0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .opcode         (opcode),
        .multiDiv       (multiDiv),
        .aluBType       (aluBType),
        .aluSrc         (aluSrc),
        .signExtendFlag (signExtendFlag),
        .memRead        (memRead),
        .memToReg       (memToReg),
        .memWrite       (memWrite),
        .aluControl     (aluControl),
        .regWrite       (regWrite),
        .jumpBranch     (jumpBranch)
`ifdef CTRL_ILLEGAL_OP_EN
        ,
        .illegalOp      (illegalBit)
`endif
    );

`ifndef CTRL_ILLEGAL_OP_EN
    assign illegalBit = 1'b0;
`endif

    // Vector layout: {aluBType,aluSrc,signExt,memRead,memToReg,memWrite,aluCtl[2],regWrite[2],jumpBranch[2],illegal}
    function automatic logic [12:0] model(input logic [3:0] op, input logic md);
        logic typeA, load, store, br, logi, ill;
        logic [1:0] alu, rw, jb;
        typeA = (op == 4'd15);
        load  = (op == 4'd10) || (op == 4'd12);
        store = (op == 4'd11) || (op == 4'd13);
        br    = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
        logi  = (op == 4'd1) || (op == 4'd2);
        alu   = br ? 2'd1 : (op == 4'd1) ? 2'd2 : (op == 4'd2) ? 2'd3 : 2'd0;
        rw    = typeA ? (md ? 2'd2 : 2'd1) : (load || logi) ? 2'd1 : 2'd0;
        jb    = br ? 2'd1 : (op == 4'd7) ? 2'd2 : (op == 4'd0) ? 2'd3 : 2'd0;
`ifdef CTRL_ILLEGAL_OP_EN
        ill   = (op == 4'd3) || (op == 4'd8) || (op == 4'd9) || (op == 4'd14);
`else
        ill   = 1'b0;
`endif
        return {typeA, load || store || logi, load || store || br, load, load, store, alu, rw, jb, ill};
    endfunction

    function automatic logic [12:0] observed();
        return {aluBType, aluSrc, signExtendFlag, memRead, memToReg, memWrite,
                aluControl, regWrite, jumpBranch, illegalBit};
    endfunction

    task automatic check(input string tag);
        logic [12:0] obs;
        obs = observed();
        vectors++;
        assert (obs === expVec)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expVec);
        end
    endtask

    // Apply inputs, clock once, advance the model, then check 1 time unit after the edge.
    task automatic step(input logic [3:0] op, input logic md, input logic st, input string tag);
        opcode = op;
        multiDiv = md;
        stall = st;
        @(posedge clk);
        if (!st) begin
            if (halted) expVec = 13'b0_0000_0000_0110;
            else begin
                expVec = model(op, md);
                halted = (op == 4'd0);
            end
        end
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic resetPulse(input string tag);
        rst = 1'b1;
        #1;
        expVec = '0;
        halted = 1'b0;
        check(tag);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_no_edge");
        @(posedge clk);
        #1;
        check("reset_held_over_edge");
        rst = 1'b0;
        step(4'hF, 1'b1, 1'b0, "typeA_md1");
        step(4'hF, 1'b0, 1'b0, "typeA_md0");
        step(4'h1, 1'b1, 1'b0, "andi");
        step(4'h2, 1'b0, 1'b0, "ori");
        step(4'hA, 1'b0, 1'b0, "lbu");
        step(4'hB, 1'b1, 1'b0, "sb");
        step(4'hC, 1'b0, 1'b0, "lw");
        step(4'hD, 1'b0, 1'b0, "sw");
        step(4'h5, 1'b0, 1'b0, "blt");
        step(4'h4, 1'b1, 1'b0, "bgt");
        step(4'h6, 1'b0, 1'b0, "beq");
        step(4'h7, 1'b0, 1'b0, "jmp");
        step(4'h3, 1'b1, 1'b0, "undef_3");
        step(4'h0, 1'b0, 1'b0, "halt");
        step(4'hF, 1'b1, 1'b0, "halted_1");
        step(4'hF, 1'b0, 1'b0, "halted_2");
        step(4'hF, 1'b1, 1'b0, "halted_3");
        resetPulse("reset_from_halted");
        step(4'hF, 1'b0, 1'b0, "typeA_after_reset");
        step(4'h1, 1'b0, 1'b0, "andi_pre_stall");
        step(4'hC, 1'b0, 1'b1, "stall_hold");
        step(4'h0, 1'b0, 1'b1, "stall_with_halt");
        step(4'hC, 1'b0, 1'b0, "lw_after_stall");
        step(4'hE, 1'b1, 1'b0, "undef_E");
        step(4'h8, 1'b0, 1'b0, "undef_8");
        step(4'h9, 1'b1, 1'b0, "undef_9");
        step(4'h1, 1'b1, 1'b0, "andi_md_ignored");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) resetPulse("rand_reset");
            else step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
